serial_nor_adder: RTL

//   Bit-serial WIDTH-bit unsigned adder. Its one-bit full adder is built only from pierce (2-input NOR) gate instances.
//   It is the stage directly downstream of pierce: it consumes pierce outputs to form sum/carry, one bit per clock.
//   A start/busy/done handshake sequences the add.
//   It is the sequential successor of the combinational NOR-gate adders and is driven by a testbench or controller.
//

---
 rtl/serial_nor_adder.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_nor_adder.sv
// Bit-serial WIDTH-bit unsigned adder whose full adder is built only from
// pierce (2-input NOR) gates; start/busy/done handshake, one bit per clock.

module pierce (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = ~(i_a | i_b);
endmodule

module serial_nor_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic             w_s, w_co;
  logic [WIDTH-1:0] w_a_sh, w_b_sh;
  logic w_n1, w_n2, w_n3, w_x, w_m1, w_m2, w_m3, w_q, w_r, w_u, w_v;

  // s: two NOR-XNOR stages, xnor(xnor(a,b),c) == a^b^c
  pierce u_n1 (.i_a(r_a[0]), .i_b(r_b[0]), .o_y(w_n1));
  pierce u_n2 (.i_a(r_a[0]), .i_b(w_n1),   .o_y(w_n2));
  pierce u_n3 (.i_a(r_b[0]), .i_b(w_n1),   .o_y(w_n3));
  pierce u_x  (.i_a(w_n2),   .i_b(w_n3),   .o_y(w_x));
  pierce u_m1 (.i_a(w_x),    .i_b(r_c),    .o_y(w_m1));
  pierce u_m2 (.i_a(w_x),    .i_b(w_m1),   .o_y(w_m2));
  pierce u_m3 (.i_a(r_c),    .i_b(w_m1),   .o_y(w_m3));
  pierce u_s  (.i_a(w_m2),   .i_b(w_m3),   .o_y(w_s));

  // co: maj = (a|b)&(a|c)&(b|c) = ~(nor(a,b) | nor(a,c) | nor(b,c))
  pierce u_q  (.i_a(r_a[0]), .i_b(r_c),    .o_y(w_q));
  pierce u_r  (.i_a(r_b[0]), .i_b(r_c),    .o_y(w_r));
  pierce u_u  (.i_a(w_n1),   .i_b(w_q),    .o_y(w_u));
  pierce u_v  (.i_a(w_u),    .i_b(w_u),    .o_y(w_v));
  pierce u_co (.i_a(w_v),    .i_b(w_r),    .o_y(w_co));

  // The A register doubles as the result shift register: sum bits enter at the MSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_a_sh = w_s;
      assign w_b_sh = 1'b0;
    end else begin : g_wn
      assign w_a_sh = {w_s,  r_a[WIDTH-1:1]};
      assign w_b_sh = {1'b0, r_b[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_a   <= w_a_sh;
          r_b   <= w_b_sh;
          r_c   <= w_co;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            sum     <= w_a_sh;
            cout    <= w_co;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
endmodule
